fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 16 +
 rtl/fetch_stage_sat_counter.sv | 26 ++
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared widths, halt opcode and FSM encoding for the fetch stage.
package fetch_stage_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 9;
    localparam int unsigned CNT_W   = 16;

    localparam logic [INSTR_W-1:0] HALT_OP = 9'h1FF;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } state_e;

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [Width-1:0] o_count
);

    logic [Width-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != {Width{1'b1}})) begin
            r_count <= r_count + Width'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Two-deep instruction fetch stage with stall, flush and HALT detection.
// Optional run-cycle counter is built only when FETCH_CYCLE_COUNT_EN is defined.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [PC_W-1:0]    startadd_i,
    input  logic [PC_W-1:0]    next_pc_i,
    output logic [PC_W-1:0]    pc_o,
    input  logic               flush_i,
    input  logic               stall_i,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    instr_pc_o,
    output logic               instr_valid_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   cycles_o
);

    state_e              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     r_addr;
    logic                r_vld;
    logic [INSTR_W-1:0]  r_instr;
    logic [PC_W-1:0]     r_instr_pc;
    logic                r_instr_valid;
    logic                r_done;
    logic                w_halt_hit;

    // Only a word from a live fetch may halt; stale memory data is ignored.
    assign w_halt_hit = r_vld && (imem_data_i == HALT_OP);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state       <= StIdle;
            r_pc          <= '0;
            r_addr        <= '0;
            r_vld         <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_done        <= 1'b0;
        end else if (start_i) begin
            r_state       <= StRun;
            r_pc          <= startadd_i;
            r_vld         <= 1'b0;
            r_instr_valid <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                StRun: begin
                    if (flush_i) begin
                        r_pc          <= next_pc_i;
                        r_vld         <= 1'b0;
                        r_instr_valid <= 1'b0;
                    end else if (!stall_i) begin
                        r_addr        <= r_pc;
                        r_vld         <= 1'b1;
                        r_pc          <= next_pc_i;
                        r_instr       <= imem_data_i;
                        r_instr_pc    <= r_addr;
                        r_instr_valid <= r_vld;
                        if (w_halt_hit) begin
                            r_state <= StHalted;
                            r_done  <= 1'b1;
                        end
                    end
                end
                StHalted: begin
                    if (!stall_i) begin
                        r_instr_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // While stalled, re-issue the held address so the in-flight read survives.
    assign imem_addr_o   = stall_i ? r_addr : r_pc;
    assign pc_o          = r_pc;
    assign instr_o       = r_instr;
    assign instr_pc_o    = r_instr_pc;
    assign instr_valid_o = r_instr_valid;
    assign done_o        = r_done;

`ifdef FETCH_CYCLE_COUNT_EN
    logic w_cnt_en;

    assign w_cnt_en = (r_state == StRun) && !start_i;

    sat_counter #(
        .Width (CNT_W)
    ) u_cycles (
        .i_clk   (clk_i),
        .i_rst   (reset_i),
        .i_clr   (start_i),
        .i_en    (w_cnt_en),
        .o_count (cycles_o)
    );
`else
    assign cycles_o = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector tables, reset sequence,
// then randomized stimulus against a queue-based fetch model.
module tb_fetch_stage;

    localparam logic [8:0] HALT = 9'h1FF;
`ifdef FETCH_CYCLE_COUNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [7:0]  startadd_i;
    logic [7:0]  next_pc_i;
    logic [7:0]  pc_o;
    logic        flush_i;
    logic        stall_i;
    logic [7:0]  imem_addr_o;
    logic [8:0]  imem_data_i;
    logic [8:0]  instr_o;
    logic [7:0]  instr_pc_o;
    logic        instr_valid_o;
    logic        done_o;
    logic [15:0] cycles_o;

    logic        use_npc;
    logic [7:0]  npc_val;
    logic [8:0]  rom [256];
    logic [8:0]  rom_q = '0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign next_pc_i   = use_npc ? npc_val : pc_o + 8'd1;
    assign imem_data_i = rom_q;

    always @(posedge clk) rom_q <= rom[imem_addr_o];

    fetch_stage dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .startadd_i    (startadd_i),
        .next_pc_i     (next_pc_i),
        .pc_o          (pc_o),
        .flush_i       (flush_i),
        .stall_i       (stall_i),
        .imem_addr_o   (imem_addr_o),
        .imem_data_i   (imem_data_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .done_o        (done_o),
        .cycles_o      (cycles_o)
    );

    typedef struct {
        logic        st;
        logic [7:0]  sa;
        logic        sl;
        logic        fl;
        logic        un;
        logic [7:0]  np;
        logic [7:0]  e_imem;
        logic [7:0]  e_pc;
        logic        e_vld;
        logic [8:0]  e_ins;
        logic [7:0]  e_ipc;
        logic        e_done;
        logic [15:0] e_cyc;
        logic        chk_cyc;
    } vec_t;

    vec_t t1[14];
    vec_t t2[9];

    function automatic vec_t v(input logic st, input logic [7:0] sa, input logic sl,
                               input logic fl, input logic un, input logic [7:0] np,
                               input logic [7:0] im, input logic [7:0] pc, input logic vl,
                               input logic [8:0] ins, input logic [7:0] ip, input logic dn,
                               input int cy, input logic cc);
        vec_t r;
        r.st = st; r.sa = sa; r.sl = sl; r.fl = fl; r.un = un; r.np = np;
        r.e_imem = im; r.e_pc = pc; r.e_vld = vl; r.e_ins = ins; r.e_ipc = ip;
        r.e_done = dn; r.e_cyc = CntEn ? 16'(cy) : 16'h0; r.chk_cyc = cc;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic [7:0] sa, input logic sl,
                         input logic fl, input logic un, input logic [7:0] np);
        start_i = st; startadd_i = sa; stall_i = sl; flush_i = fl;
        use_npc = un; npc_val = np;
    endtask

    task automatic run_vec(input vec_t r, input string tag, input int idx);
        string p;
        p = $sformatf("%s[%0d]", tag, idx);
        drive(r.st, r.sa, r.sl, r.fl, r.un, r.np);
        #1;
        chk({p, ".imem_addr"}, 16'(imem_addr_o), 16'(r.e_imem));
        @(posedge clk);
        #1;
        chk({p, ".pc"}, 16'(pc_o), 16'(r.e_pc));
        chk({p, ".valid"}, 16'(instr_valid_o), 16'(r.e_vld));
        chk({p, ".done"}, 16'(done_o), 16'(r.e_done));
        if (r.e_vld) begin
            chk({p, ".instr"}, 16'(instr_o), 16'(r.e_ins));
            chk({p, ".instr_pc"}, 16'(instr_pc_o), 16'(r.e_ipc));
        end
        if (r.chk_cyc) chk({p, ".cycles"}, cycles_o, r.e_cyc);
    endtask

    // Reference model: addresses issued to memory wait in a queue and come out
    // one unstalled edge later; a flush or start discards whatever is queued.
    logic [7:0]  m_q[$];
    logic [7:0]  m_pc, m_last, m_ipc;
    logic [8:0]  m_ins;
    logic        m_vld, m_done, m_run, m_halt;
    int unsigned m_cyc;

    task automatic model_reset();
        m_q.delete();
        m_pc = 8'h0; m_last = 8'h0; m_ipc = 8'h0; m_ins = 9'h0;
        m_vld = 1'b0; m_done = 1'b0; m_run = 1'b0; m_halt = 1'b0; m_cyc = 0;
    endtask

    task automatic model_edge(input logic st, input logic [7:0] sa, input logic sl,
                              input logic fl, input logic [7:0] np);
        logic [7:0] a;
        if (st) begin
            m_q.delete();
            m_pc = sa; m_vld = 1'b0; m_done = 1'b0; m_cyc = 0;
            m_run = 1'b1; m_halt = 1'b0;
        end else if (m_run && !m_halt) begin
            if (m_cyc < 65535) m_cyc++;
            if (fl) begin
                m_q.delete();
                m_pc = np; m_vld = 1'b0;
            end else if (!sl) begin
                if (m_q.size() > 0) begin
                    a = m_q.pop_front();
                    m_vld = 1'b1; m_ipc = a; m_ins = rom[a];
                    if (m_ins == HALT) begin
                        m_halt = 1'b1; m_done = 1'b1;
                    end
                end else begin
                    m_vld = 1'b0;
                end
                m_q.push_back(m_pc);
                m_last = m_pc;
                m_pc = np;
            end
        end else if (m_halt && !sl) begin
            m_vld = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, actual running, required done");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       st, sl, fl, un;
        logic [7:0] sa, np, npm;
        bit         reached;

        for (int a = 0; a < 256; a++) rom[a] = 9'(a);
        drive(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 8'h0);

        // Start / stall / flush walk with ROM[a] = a.
        t1[0]  = v(1, 8'h10, 0, 0, 0, 8'h00, 8'h00, 8'h10, 0, 9'h000, 8'h00, 0, 0, 0);
        t1[1]  = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h10, 8'h11, 0, 9'h000, 8'h00, 0, 0, 0);
        t1[2]  = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h11, 8'h12, 1, 9'h010, 8'h10, 0, 0, 0);
        t1[3]  = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h12, 8'h13, 1, 9'h011, 8'h11, 0, 0, 0);
        t1[4]  = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h13, 8'h14, 1, 9'h012, 8'h12, 0, 0, 0);
        t1[5]  = v(0, 8'h00, 1, 0, 0, 8'h00, 8'h13, 8'h14, 1, 9'h012, 8'h12, 0, 0, 0);
        t1[6]  = v(0, 8'h00, 1, 0, 0, 8'h00, 8'h13, 8'h14, 1, 9'h012, 8'h12, 0, 0, 0);
        t1[7]  = v(0, 8'h00, 1, 0, 0, 8'h00, 8'h13, 8'h14, 1, 9'h012, 8'h12, 0, 0, 0);
        t1[8]  = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h14, 8'h15, 1, 9'h013, 8'h13, 0, 0, 0);
        t1[9]  = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h15, 8'h16, 1, 9'h014, 8'h14, 0, 0, 0);
        t1[10] = v(0, 8'h00, 0, 1, 1, 8'h2A, 8'h16, 8'h2A, 0, 9'h000, 8'h00, 0, 0, 0);
        t1[11] = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h2A, 8'h2B, 0, 9'h000, 8'h00, 0, 0, 0);
        t1[12] = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h2B, 8'h2C, 1, 9'h02A, 8'h2A, 0, 0, 0);
        t1[13] = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h2C, 8'h2D, 1, 9'h02B, 8'h2B, 0, 0, 0);

        // HALT at 0x05, one stalled cycle so the run lasts five edges.
        t2[0] = v(1, 8'h03, 0, 0, 0, 8'h00, 8'h00, 8'h03, 0, 9'h000, 8'h00, 0, 0, 1);
        t2[1] = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h03, 8'h04, 0, 9'h000, 8'h00, 0, 1, 1);
        t2[2] = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h04, 8'h05, 1, 9'h003, 8'h03, 0, 2, 1);
        t2[3] = v(0, 8'h00, 1, 0, 0, 8'h00, 8'h04, 8'h05, 1, 9'h003, 8'h03, 0, 3, 1);
        t2[4] = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h05, 8'h06, 1, 9'h004, 8'h04, 0, 4, 1);
        t2[5] = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h06, 8'h07, 1, 9'h1FF, 8'h05, 1, 5, 1);
        t2[6] = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h07, 8'h07, 0, 9'h000, 8'h00, 1, 5, 1);
        t2[7] = v(0, 8'h00, 0, 1, 1, 8'h99, 8'h07, 8'h07, 0, 9'h000, 8'h00, 1, 5, 1);
        t2[8] = v(1, 8'h40, 1, 1, 1, 8'h99, 8'h06, 8'h40, 0, 9'h000, 8'h00, 0, 0, 1);

        // Power-on reset.
        reset_i = 1'b1;
        #1;
        chk("por.pc", 16'(pc_o), 16'h0);
        chk("por.valid", 16'(instr_valid_o), 16'h0);
        chk("por.instr", 16'(instr_o), 16'h0);
        chk("por.cycles", cycles_o, 16'h0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(t1[i], "start_stall_flush", i);

        // Reset in the middle of a run at pc 0x30.
        drive(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 8'h0);
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            if (pc_o == 8'h30) reached = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("rst.reach_pc30", 16'(pc_o), 16'h30);
        #2;
        reset_i = 1'b1;
        #1;
        chk("rst.pc", 16'(pc_o), 16'h0);
        chk("rst.imem_addr", 16'(imem_addr_o), 16'h0);
        chk("rst.instr", 16'(instr_o), 16'h0);
        chk("rst.instr_pc", 16'(instr_pc_o), 16'h0);
        chk("rst.valid", 16'(instr_valid_o), 16'h0);
        chk("rst.done", 16'(done_o), 16'h0);
        chk("rst.cycles", cycles_o, 16'h0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h0, 1'(i), 1'b1, 1'b1, 8'h55);
            @(posedge clk);
            #1;
            chk($sformatf("idle[%0d].valid", i), 16'(instr_valid_o), 16'h0);
            chk($sformatf("idle[%0d].pc", i), 16'(pc_o), 16'h0);
            chk($sformatf("idle[%0d].cycles", i), cycles_o, 16'h0);
        end

        rom[5] = HALT;
        for (int i = 0; i < 9; i++) run_vec(t2[i], "halt", i);

        // Randomized run against the model.
        drive(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 8'h0);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        model_reset();
        for (int a = 0; a < 256; a++) rom[a] = 9'($urandom_range(0, 510));
        for (int k = 0; k < 6; k++) rom[$urandom_range(0, 255)] = HALT;

        for (int i = 0; i < 400; i++) begin
            st = (i == 0) || ($urandom_range(0, 39) == 0);
            sa = 8'($urandom);
            sl = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 9) == 0);
            un = ($urandom_range(0, 7) == 0);
            np = 8'($urandom);
            drive(st, sa, sl, fl, un, np);
            #1;
            chk("rnd.imem_addr", 16'(imem_addr_o), 16'(sl ? m_last : m_pc));
            npm = un ? np : m_pc + 8'd1;
            @(posedge clk);
            model_edge(st, sa, sl, fl, npm);
            #1;
            chk("rnd.pc", 16'(pc_o), 16'(m_pc));
            chk("rnd.valid", 16'(instr_valid_o), 16'(m_vld));
            chk("rnd.done", 16'(done_o), 16'(m_done));
            chk("rnd.cycles", cycles_o, CntEn ? 16'(m_cyc) : 16'h0);
            if (m_vld) begin
                chk("rnd.instr", 16'(instr_o), 16'(m_ins));
                chk("rnd.instr_pc", 16'(instr_pc_o), 16'(m_ipc));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
